mem_responder: RTL and testbench

Memory-side responder for the cache's fill and write-through traffic. It accepts one 16-bit word request at a time over a valid/ready handshake, performs the access as two sequential byte operations on a byte-organised backing store (little-endian), and returns a single-cycle response. It sits between the cache and the byte RAM, replacing the zero-latency direct array access with a timed, handshaken memory port.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_byte_ram.sv | 24 ++
 rtl/mem_responder.sv | 97 +++++++++
 tb/tb_mem_responder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and widths for the handshaken word-over-byte memory responder.
package mem_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LO,
    S_HI,
    S_RESP
  } state_t;

endpackage

// File: rtl/mem_byte_ram.sv
// Single-port byte store: synchronous write, registered read (read-before-write).
module mem_byte_ram
  import mem_pkg::*;
#(
  parameter int unsigned RAM_BYTES = 65536,
  localparam int unsigned AW = (RAM_BYTES > 1) ? $clog2(RAM_BYTES) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [BYTE_W-1:0] wdata,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [RAM_BYTES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Accepts one 16-bit word request, performs it as two little-endian byte
// accesses after LATENCY wait cycles, then pulses a one-cycle response.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned RAM_BYTES = 65536,
  parameter int unsigned LATENCY   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              busy
);

  localparam int unsigned AW = (RAM_BYTES > 1) ? $clog2(RAM_BYTES) : 1;

  state_t            state;
  logic [3:0]        cnt;
  logic              wr_q;
  logic [AW-1:0]     a0_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BYTE_W-1:0] lo_q;

  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [BYTE_W-1:0] ram_wdata;
  logic [BYTE_W-1:0] ram_rdata;

  // Byte writes are gated by rst so an aborted HI cycle leaves the high byte untouched.
  always_comb begin
    ram_we    = !rst && wr_q && ((state == S_LO) || (state == S_HI));
    ram_addr  = (state == S_HI) ? a0_q + AW'(1) : a0_q;
    ram_wdata = (state == S_HI) ? wdata_q[15:8] : wdata_q[7:0];
  end

  mem_byte_ram #(
    .RAM_BYTES (RAM_BYTES)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      a0_q    <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            a0_q    <= req_addr[AW-1:0];
            wdata_q <= req_wdata;
            cnt     <= 4'(LATENCY);
            state   <= (LATENCY == 0) ? S_LO : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) begin
            state <= S_LO;
          end
        end
        S_LO: state <= S_HI;
        // Registered RAM read: the low byte issued in LO lands here.
        S_HI: begin
          lo_q  <= ram_rdata;
          state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // The high byte issued in HI is on ram_rdata during RESP.
  always_comb begin
    req_ready  = (state == S_IDLE) && !rst;
    busy       = (state != S_IDLE);
    resp_valid = (state == S_RESP);
    resp_rdata = (resp_valid && !wr_q) ? {ram_rdata, lo_q} : '0;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (LATENCY=2 main instance, LATENCY=0 second instance).
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr  = '0;
  logic [15:0] req_wdata = '0;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        busy;

  logic        v0 = 1'b0;
  logic        rdy0;
  logic        wr0 = 1'b0;
  logic [15:0] ad0 = '0;
  logic [15:0] wd0 = '0;
  logic        rv0;
  logic [15:0] rd0;
  logic        busy0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_responder #(.RAM_BYTES(65536), .LATENCY(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .busy       (busy)
  );

  mem_responder #(.RAM_BYTES(65536), .LATENCY(0)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (v0),
    .req_ready  (rdy0),
    .req_write  (wr0),
    .req_addr   (ad0),
    .req_wdata  (wd0),
    .resp_valid (rv0),
    .resp_rdata (rd0),
    .busy       (busy0)
  );

  // Issues one request on the main instance; lat is the response cycle
  // counted from acceptance (-1 on timeout), dirty counts nonzero idle rdata.
  task automatic run_req(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                         output logic [15:0] rd, output int lat, output int dirty);
    int w;
    lat   = -1;
    rd    = 'x;
    dirty = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    if (!req_ready) begin req_valid = 1'b0; return; end
    @(posedge clk); #1 req_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (resp_valid) begin lat = c; rd = resp_rdata; break; end
      else if (resp_rdata !== 16'h0) dirty++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b want=0", resp_valid); end
    total++; if (resp_rdata !== 16'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0000", resp_rdata); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL rst_ready0 got=%b want=0", rdy0); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_write_read;
    logic [15:0] rd; int lat, dirty;
    run_req(1'b1, 16'h0010, 16'hBEEF, rd, lat, dirty);
    total++; if (lat !== 5) begin bad++; $display("FAIL wr_latency got=%0d want=5", lat); end
    total++; if (rd !== 16'h0) begin bad++; $display("FAIL wr_rdata got=%h want=0000", rd); end
    total++; if (dirty !== 0) begin bad++; $display("FAIL wr_idle_rdata got=%0d want=0", dirty); end
    run_req(1'b0, 16'h0010, 16'h0000, rd, lat, dirty);
    total++; if (lat !== 5) begin bad++; $display("FAIL rd_latency got=%0d want=5", lat); end
    total++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL rd_0010 got=%h want=beef", rd); end
    total++; if (dirty !== 0) begin bad++; $display("FAIL rd_idle_rdata got=%0d want=0", dirty); end
    run_req(1'b0, 16'h0011, 16'h0000, rd, lat, dirty);
    total++; if (rd[7:0] !== 8'hBE) begin bad++; $display("FAIL byte_0011 got=%h want=be", rd[7:0]); end
    run_req(1'b0, 16'h000F, 16'h0000, rd, lat, dirty);
    total++; if (rd[15:8] !== 8'hEF) begin bad++; $display("FAIL byte_0010 got=%h want=ef", rd[15:8]); end
  endtask

  task automatic test_wrap;
    logic [15:0] rd; int lat, dirty;
    run_req(1'b1, 16'hFFFF, 16'h1234, rd, lat, dirty);
    run_req(1'b0, 16'hFFFF, 16'h0000, rd, lat, dirty);
    total++; if (rd !== 16'h1234) begin bad++; $display("FAIL wrap_rd got=%h want=1234", rd); end
    run_req(1'b0, 16'h0000, 16'h0000, rd, lat, dirty);
    total++; if (rd[7:0] !== 8'h12) begin bad++; $display("FAIL byte_0000 got=%h want=12", rd[7:0]); end
    run_req(1'b0, 16'hFFFE, 16'h0000, rd, lat, dirty);
    total++; if (rd[15:8] !== 8'h34) begin bad++; $display("FAIL byte_ffff got=%h want=34", rd[15:8]); end
  endtask

  task automatic test_overlap;
    logic [15:0] rd; int lat, dirty;
    run_req(1'b1, 16'h0020, 16'hAABB, rd, lat, dirty);
    run_req(1'b1, 16'h0021, 16'hCCDD, rd, lat, dirty);
    run_req(1'b0, 16'h0020, 16'h0000, rd, lat, dirty);
    total++; if (rd !== 16'hDDBB) begin bad++; $display("FAIL ovl_0020 got=%h want=ddbb", rd); end
    run_req(1'b0, 16'h0021, 16'h0000, rd, lat, dirty);
    total++; if (rd !== 16'hCCDD) begin bad++; $display("FAIL ovl_0021 got=%h want=ccdd", rd); end
  endtask

  task automatic test_back_to_back;
    int w, first_ready, resp1, resp2, dirty;
    logic [15:0] rd1, rd2;
    first_ready = -1; resp1 = -1; resp2 = -1; dirty = 0; rd1 = 'x; rd2 = 'x;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0010;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk); #1 req_addr = 16'h0020;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (resp_valid && resp1 < 0) begin resp1 = c; rd1 = resp_rdata; end
      else if (!resp_valid && resp_rdata !== 16'h0) dirty++;
      if (req_ready) begin first_ready = c; break; end
    end
    @(posedge clk); #1 req_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (resp_valid) begin resp2 = c; rd2 = resp_rdata; break; end
      else if (resp_rdata !== 16'h0) dirty++;
    end
    total++; if (first_ready !== 6) begin bad++; $display("FAIL bp_accept2 got=%0d want=6", first_ready); end
    total++; if (resp1 !== 5) begin bad++; $display("FAIL bp_resp1 got=%0d want=5", resp1); end
    total++; if (rd1 !== 16'hBEEF) begin bad++; $display("FAIL bp_rd1 got=%h want=beef", rd1); end
    total++; if (resp2 !== 5) begin bad++; $display("FAIL bp_resp2 got=%0d want=5", resp2); end
    total++; if (rd2 !== 16'hDDBB) begin bad++; $display("FAIL bp_rd2 got=%h want=ddbb", rd2); end
    total++; if (dirty !== 0) begin bad++; $display("FAIL bp_idle_rdata got=%0d want=0", dirty); end
  endtask

  task automatic test_reset_mid_write;
    logic [15:0] rd; int lat, dirty, w, resps;
    logic busy_hi, ready_after;
    run_req(1'b1, 16'h0030, 16'h0000, rd, lat, dirty);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0030; req_wdata = 16'h5678;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk); #1 req_valid = 1'b0;
    resps = 0;
    repeat (4) begin @(negedge clk); if (resp_valid) resps++; end
    busy_hi = busy;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 ready_after = req_ready;
    repeat (4) begin @(negedge clk); if (resp_valid) resps++; end
    total++; if (busy_hi !== 1'b1) begin bad++; $display("FAIL rmw_busy_hi got=%b want=1", busy_hi); end
    total++; if (ready_after !== 1'b1) begin bad++; $display("FAIL rmw_ready got=%b want=1", ready_after); end
    total++; if (resps !== 0) begin bad++; $display("FAIL rmw_no_resp got=%0d want=0", resps); end
    run_req(1'b0, 16'h0030, 16'h0000, rd, lat, dirty);
    total++; if (rd !== 16'h0078) begin bad++; $display("FAIL rmw_partial got=%h want=0078", rd); end
  endtask

  task automatic test_latency0;
    int w, respc, acc, lat;
    logic [15:0] rd;
    respc = -1; acc = -1; lat = -1; rd = 'x;
    @(negedge clk);
    v0 = 1'b1; wr0 = 1'b1; ad0 = 16'h0005; wd0 = 16'h4321;
    w = 0;
    while (!rdy0 && w < 50) begin @(negedge clk); w++; end
    @(posedge clk); #1 wr0 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (rv0 && respc < 0) respc = c;
      if (rdy0) begin acc = c; break; end
    end
    @(posedge clk); #1 v0 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (rv0) begin lat = c; rd = rd0; break; end
    end
    total++; if (respc !== 3) begin bad++; $display("FAIL l0_resp got=%0d want=3", respc); end
    total++; if (acc !== 4) begin bad++; $display("FAIL l0_accept2 got=%0d want=4", acc); end
    total++; if (lat !== 3) begin bad++; $display("FAIL l0_rd_latency got=%0d want=3", lat); end
    total++; if (rd !== 16'h4321) begin bad++; $display("FAIL l0_rd got=%h want=4321", rd); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_wrap;
    test_overlap;
    test_back_to_back;
    test_reset_mid_write;
    test_latency0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
